// File: rtl/seq_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_ctrl
// Description : Records a sequence of 4-bit codes from player 1, then checks
//               player 2's replay code-by-code under a per-entry timer.
// Revision    : 1.0  initial release
// ============================================================================
module seq_match_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [3:0] Code,
    input  logic       CodeValid,
    input  logic       EndRec,
    output logic       Allow,
    output logic [3:0] Len,
    output logic [3:0] Pos,
    output logic       Win,
    output logic       Lose,
    output logic       TimedOut,
    output logic [2:0] State
);

    localparam logic [2:0]    C_IDLE     = 3'd0;
    localparam logic [2:0]    C_REC      = 3'd1;
    localparam logic [2:0]    C_ARM      = 3'd2;
    localparam logic [2:0]    C_PLAY     = 3'd3;
    localparam logic [2:0]    C_WIN      = 3'd4;
    localparam logic [2:0]    C_LOSE     = 3'd5;
    localparam logic [3:0]    C_DEPTH    = 4'(DEPTH);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state_q,  state_d;
    logic [3:0]    len_q,    len_d;
    logic [3:0]    pos_q,    pos_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          win_q,    win_d;
    logic          lose_q,   lose_d;
    logic          to_q,     to_d;
    logic          allow_q,  allow_d;
    logic          mem_we;
    logic          code_match;
    logic          last_pos;
    logic          timer_exp;

    // Sized to the full 4-bit address range so Len/Pos index it directly.
    logic [3:0]    mem_q [16];

    assign code_match = (Code == mem_q[pos_q]);
    assign last_pos   = ((pos_q + 4'd1) == len_q);
    assign timer_exp  = (timer_q == C_TMO_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= C_IDLE;
            len_q   <= 4'd0;
            pos_q   <= 4'd0;
            timer_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            to_q    <= 1'b0;
            allow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            to_q    <= to_d;
            allow_q <= allow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[len_q] <= Code;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: if (Start) state_d = C_REC;
            C_REC: begin
                if (CodeValid && ((len_q + 4'd1) == C_DEPTH)) begin
                    state_d = C_ARM;
                end else if (EndRec && (CodeValid || (len_q != 4'd0))) begin
                    state_d = C_ARM;
                end
            end
            C_ARM:  state_d = C_PLAY;
            C_PLAY: begin
                // A same-cycle entry takes precedence over timer expiry.
                if (CodeValid) begin
                    if (!code_match)   state_d = C_LOSE;
                    else if (last_pos) state_d = C_WIN;
                end else if (timer_exp) begin
                    state_d = C_LOSE;
                end
            end
            C_WIN, C_LOSE: if (Start) state_d = C_REC;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        pos_d   = pos_q;
        timer_d = timer_q;
        win_d   = win_q;
        lose_d  = lose_q;
        to_d    = to_q;
        mem_we  = 1'b0;
        allow_d = (state_d == C_REC) || (state_d == C_PLAY);
        case (state_q)
            C_IDLE: begin
                if (Start) begin
                    len_d = 4'd0;
                    pos_d = 4'd0;
                end
            end
            C_REC: begin
                if (CodeValid) begin
                    mem_we = 1'b1;
                    len_d  = len_q + 4'd1;
                end
            end
            C_ARM: begin
                pos_d   = 4'd0;
                timer_d = '0;
            end
            C_PLAY: begin
                if (CodeValid) begin
                    if (code_match) begin
                        pos_d   = pos_q + 4'd1;
                        timer_d = '0;
                        win_d   = last_pos;
                    end else begin
                        lose_d = 1'b1;
                        to_d   = 1'b0;
                    end
                end else if (timer_exp) begin
                    lose_d = 1'b1;
                    to_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            C_WIN, C_LOSE: begin
                if (Start) begin
                    win_d  = 1'b0;
                    lose_d = 1'b0;
                    to_d   = 1'b0;
                    len_d  = 4'd0;
                    pos_d  = 4'd0;
                end
            end
            default: ;
        endcase
    end

    assign Allow    = allow_q;
    assign Len      = len_q;
    assign Pos      = pos_q;
    assign Win      = win_q;
    assign Lose     = lose_q;
    assign TimedOut = to_q;
    assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_match_ctrl
// Description : Vector-table bench for seq_match_ctrl with an expected queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_match_ctrl;

    localparam int C_TMO = 20;

    localparam logic [2:0] I = 3'd0, R = 3'd1, A = 3'd2, P = 3'd3, W = 3'd4, L = 3'd5;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] Code = 4'd0;
    logic       CodeValid = 1'b0;
    logic       EndRec = 1'b0;
    logic       Allow;
    logic [3:0] Len;
    logic [3:0] Pos;
    logic       Win;
    logic       Lose;
    logic       TimedOut;
    logic [2:0] State;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start;
        logic [3:0] code;
        logic       cv;
        logic       endrec;
        logic [2:0] st;
        logic [3:0] len;
        logic [3:0] pos;
        logic       win;
        logic       lose;
        logic       to;
        logic       allow;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    seq_match_ctrl #(.DEPTH(8), .TIMEOUT(C_TMO), .TW(16)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Code(Code), .CodeValid(CodeValid),
        .EndRec(EndRec), .Allow(Allow), .Len(Len), .Pos(Pos), .Win(Win),
        .Lose(Lose), .TimedOut(TimedOut), .State(State)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t v(logic s, logic [3:0] c, logic cv, logic er,
                               logic [2:0] st, logic [3:0] len, logic [3:0] pos,
                               logic win, logic lose, logic to, logic allow);
        vec_t x;
        x.start = s;  x.code = c;  x.cv = cv;  x.endrec = er;
        x.st = st;    x.len = len; x.pos = pos;
        x.win = win;  x.lose = lose; x.to = to; x.allow = allow;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, " State"},    int'(State),    int'(e.st));
        chk({tag, " Len"},      int'(Len),      int'(e.len));
        chk({tag, " Pos"},      int'(Pos),      int'(e.pos));
        chk({tag, " Win"},      int'(Win),      int'(e.win));
        chk({tag, " Lose"},     int'(Lose),     int'(e.lose));
        chk({tag, " TimedOut"}, int'(TimedOut), int'(e.to));
        chk({tag, " Allow"},    int'(Allow),    int'(e.allow));
    endtask

    // Drive each vector at the falling edge, compare just after the rising edge.
    task automatic run_tbl(input string tag);
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            Start = tbl[i].start; Code = tbl[i].code;
            CodeValid = tbl[i].cv; EndRec = tbl[i].endrec;
            exp_q.push_back(tbl[i]);
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            check_all($sformatf("%s[%0d]", tag, i), e);
        end
        @(negedge Clk);
        Start = 1'b0; CodeValid = 1'b0; EndRec = 1'b0; Code = 4'd0;
        tbl.delete();
    endtask

    initial begin : main
        logic [3:0] seq8 [8];
        vec_t       rst_exp;
        seq8[0] = 4'd1;  seq8[1] = 4'd2;  seq8[2] = 4'd5;  seq8[3] = 4'd7;
        seq8[4] = 4'd0;  seq8[5] = 4'd12; seq8[6] = 4'd14; seq8[7] = 4'd15;
        rst_exp = v(0, 0, 0, 0, I, 0, 0, 0, 0, 0, 0);

        #12;
        check_all("reset", rst_exp);
        @(negedge Clk);
        Rst = 1'b0;

        // Record 5,9,2 then replay with 10-cycle spacing; Start/EndRec in PLAY ignored.
        tbl.push_back(v(1, 0, 0, 0, R, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 5, 1, 0, R, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 9, 1, 0, R, 2, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 2, 1, 0, R, 3, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, A, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, P, 3, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            logic [3:0] c;
            c = (k == 0) ? 4'd5 : (k == 1) ? 4'd9 : 4'd2;
            for (int j = 0; j < 9; j++)
                tbl.push_back(v(j == 3, 0, 0, j == 5, P, 3, 4'(k), 0, 0, 0, 1));
            if (k < 2) tbl.push_back(v(0, c, 1, 0, P, 3, 4'(k + 1), 0, 0, 0, 1));
            else       tbl.push_back(v(0, c, 1, 0, W, 3, 3, 1, 0, 0, 0));
        end
        tbl.push_back(v(0, 0, 0, 0, W, 3, 3, 1, 0, 0, 0));
        run_tbl("replay3");

        // Fill all 8 slots; CodeValid during ARM ignored; 4th replay entry wrong.
        tbl.push_back(v(1, 0, 0, 0, R, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 8; k++) begin
            if (k == 3) tbl.push_back(v(1, 0, 0, 0, R, 3, 0, 0, 0, 0, 1));
            if (k < 7) tbl.push_back(v(0, seq8[k], 1, 0, R, 4'(k + 1), 0, 0, 0, 0, 1));
            else       tbl.push_back(v(0, seq8[k], 1, 0, A, 8, 0, 0, 0, 0, 0));
        end
        tbl.push_back(v(0, 1, 1, 0, P, 8, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, P, 8, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 2, 1, 0, P, 8, 2, 0, 0, 0, 1));
        tbl.push_back(v(0, 5, 1, 0, P, 8, 3, 0, 0, 0, 1));
        tbl.push_back(v(0, 3, 1, 0, L, 8, 3, 0, 1, 0, 0));
        tbl.push_back(v(0, 7, 1, 0, L, 8, 3, 0, 1, 0, 0));
        run_tbl("depth8");

        // From LOSE: restart, EndRec with nothing recorded, code 0 + EndRec, timeout.
        tbl.push_back(v(1, 0, 0, 0, R, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, R, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, A, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, P, 1, 0, 0, 0, 0, 1));
        for (int j = 0; j < C_TMO - 1; j++)
            tbl.push_back(v(0, 0, 0, 0, P, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, L, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, L, 1, 0, 0, 1, 1, 0));
        run_tbl("timeout");

        // Correct entry on the expiry cycle wins; also proves mem[0] holds code 0.
        tbl.push_back(v(1, 0, 0, 0, R, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, A, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, P, 1, 0, 0, 0, 0, 1));
        for (int j = 0; j < C_TMO - 1; j++)
            tbl.push_back(v(0, 0, 0, 0, P, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, W, 1, 1, 1, 0, 0, 0));
        run_tbl("expiry_hit");

        // Asynchronous reset mid-PLAY with Len=3, Pos=1.
        tbl.push_back(v(1, 0, 0, 0, R, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 3, 1, 0, R, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 4, 1, 0, R, 2, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 5, 1, 0, R, 3, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, A, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, P, 3, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 3, 1, 0, P, 3, 1, 0, 0, 0, 1));
        run_tbl("pre_rst");
        #2;
        Rst = 1'b1;
        #1;
        check_all("mid_rst", rst_exp);
        @(negedge Clk);
        Rst = 1'b0;

        if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Sequence record/compare controller sitting directly downstream of the 4-bit player load register in the two-player memory game.
- Player 1 records a sequence of up to DEPTH 4-bit codes. Player 2 must then reproduce it code-by-code, each entry within TIMEOUT cycles.
- Drives the load register's Allow enable and reports win/lose/timeout to the display/score logic.

Parameters:
- DEPTH, 8, maximum sequence length in codes (2..15).
- TIMEOUT, 1000, cycles allowed per player-2 entry (>=2).
- TW, 16, timer width; TIMEOUT must be < 2^TW.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  one-cycle pulse: begin a new round (recording).
- Code  in  4  code value from the load register output.
- CodeValid  in  1  one-cycle pulse: Code holds a new player entry this cycle.
- EndRec  in  1  one-cycle pulse: player 1 finishes recording.
- Allow  out  1  enable to the load register; high only in REC and PLAY.
- Len  out  4  number of codes recorded.
- Pos  out  4  index of the next code player 2 must enter.
- Win  out  1  sticky; player 2 reproduced the full sequence.
- Lose  out  1  sticky; mismatch or timeout.
- TimedOut  out  1  sticky; set together with Lose when the loss was caused by the timer.
- State  out  3  FSM state encoding, for debug and display.

Behaviour:
- Every output is a register, updated on the Clk rising edge.
- FSM states and encodings: IDLE=0, REC=1, ARM=2, PLAY=3, WIN=4, LOSE=5.
- Reset (async, any state, including mid-round):
  - State=IDLE.
  - Len, Pos, timer, Win, Lose, TimedOut, Allow all 0.
  - Sequence memory is not reset; contents are don't-care.
- IDLE: Start -> REC with Len=0. All other inputs ignored.
- REC, Allow=1:
  - CodeValid: mem[Len]<=Code, Len<=Len+1.
  - If the write makes Len==DEPTH -> ARM; further codes are not possible.
  - EndRec with Len>=1 -> ARM. EndRec with Len==0 is ignored; stay in REC.
  - CodeValid and EndRec in the same cycle: the code is written and counted, then -> ARM.
  - Start in REC is ignored.
- ARM: exactly one cycle.
  - Allow=0, which forces the load register to clear.
  - Pos<=0, timer<=0, then -> PLAY.
  - CodeValid in ARM is ignored.
- PLAY, Allow=1, timer increments every cycle with no CodeValid.
  - CodeValid with Code==mem[Pos]: Pos<=Pos+1, timer<=0. If Pos+1==Len -> WIN with Win<=1.
  - CodeValid with Code!=mem[Pos]: -> LOSE with Lose<=1, TimedOut=0. Pos is held.
  - No CodeValid and timer==TIMEOUT-1: -> LOSE with Lose<=1, TimedOut<=1. The expiry edge is TIMEOUT cycles after PLAY entry or after the last match.
  - CodeValid in the same cycle as timer expiry: the entry is evaluated and the timer is ignored.
  - Start and EndRec in PLAY are ignored.
- WIN/LOSE:
  - Allow=0; all outputs hold.
  - Start -> REC: clears Win, Lose and TimedOut, sets Len=0, Pos=0.
- Win/Lose are visible the cycle after the deciding CodeValid or expiry edge. Win and Lose are never both 1.
- Code value 0 is a legal code; only CodeValid qualifies an entry.

Test Plan:
- Reset mid-PLAY (Len=3, Pos=1) -> same-cycle State=0, Allow=0, Len=0, Pos=0, Win=Lose=0.
- Start; record 5,9,2; EndRec; replay 5,9,2 each 10 cycles apart -> Len=3, ARM lasts 1 cycle with Allow=0, Pos 0->1->2->3, Win=1 after the third entry, State=4.
- Record 8 codes (DEPTH=8) without EndRec -> ARM entered after the 8th write, Len=8. Replay with the 4th code wrong (3 instead of 7) -> Lose=1, TimedOut=0, Pos=3.
- TIMEOUT=20: record 1 code, enter nothing in PLAY -> Lose=1 and TimedOut=1 exactly 20 cycles after PLAY entry. Repeat with CodeValid (correct code) on the expiry cycle -> Win=1, TimedOut=0.
- EndRec with Len=0 -> stays REC. CodeValid(Code=0) and EndRec in the same cycle -> Len=1, mem[0]=0, ARM next.
- From LOSE, pulse Start -> REC, Win=Lose=TimedOut=0, Len=0. Start pulsed during REC/PLAY -> no effect.
